regfile_serial_nxw: RTL and testbench
=====================================

// Module: regfile_serial_nxw
// PURPOSE
//  Parametrised NREGS x XLEN register file for the bit-serial datapath.
//  - Streams two source operands out LSB-first, one bit per cycle over XLEN cycles.
//  - Captures the serial result bit stream in the same window and commits it to rd.
//  - Parallel load port (boot/test) and combinational debug read port. Sits between
//    the sequencer and the 1-bit ALU.
// PARAMETERS
//  XLEN      32  register width / serial window length (>=2)
//  NREGS     32  number of registers (power of 2, >=2)
//  AW        5   address width, must equal log2(NREGS)
//  ZERO_REG  1   1: register 0 reads 0, writes to it discarded; 0: ordinary register
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rstn       in   1     asynchronous active-low reset
//  start      in   1     begin serial op; rs1/rs2/rd/we sampled when accepted
//  rs1, rs2   in   AW    source addresses
//  rd         in   AW    destination address
//  we         in   1     commit the serial result at end of op
//  wd_bit     in   1     result bit, sampled every SHIFT cycle
//  rd1_bit    out  1     operand-1 bit for the current SHIFT cycle
//  rd2_bit    out  1     operand-2 bit for the current SHIFT cycle
//  bit_idx    out  AW'   current bit index 0..XLEN-1, width $clog2(XLEN)
//  busy       out  1     high in SHIFT and COMMIT
//  done       out  1     one-cycle pulse in the COMMIT cycle
//  par_we     in   1     parallel write request
//  par_addr   in   AW    parallel write address
//  par_wd     in   XLEN  parallel write data
//  par_ack    out  1     pulses the cycle after a parallel write is performed
//  dbg_addr   in   AW    debug read address
//  dbg_rdata  out  XLEN  regs[dbg_addr], combinational; 0 for reg 0 if ZERO_REG
// BEHAVIOUR
//  - Reset (async, rstn=0):
//    - all registers, shift regs and bit_idx cleared; state=IDLE
//    - busy=done=par_ack=rd1_bit=rd2_bit=0
//    - in-flight op aborted, no commit
//  - FSM IDLE -> SHIFT -> COMMIT -> IDLE.
//  - IDLE, start=1 (cycle T):
//    - load sh1<=regs[rs1], sh2<=regs[rs2] (0 for reg 0 if ZERO_REG)
//    - latch rd, we; bit_idx<=0; ->SHIFT
//  - SHIFT, cycles T+1..T+XLEN:
//    - rd1_bit=sh1[0], rd2_bit=sh2[0]
//    - each edge: sh1/sh2 shift right; wsh<={wd_bit,wsh[XLEN-1:1]}; bit_idx++
//    - leave SHIFT when bit_idx==XLEN-1 -> COMMIT
//  - COMMIT, cycle T+XLEN+1:
//    - done=1, busy=1
//    - at edge, if latched we && !(ZERO_REG && rd==0): regs[rd]<=wsh
//    - ->IDLE; value visible on dbg_rdata at T+XLEN+2
//  - start while in SHIFT: ignored. start in COMMIT: see CONFIGURATION.
//  - Parallel write: performed only in IDLE with start=0.
//    - start and par_we together in IDLE: start wins, write dropped, par_ack stays 0
//    - par_we while busy: dropped, par_ack=0
//    - reg 0 write discarded when ZERO_REG, but par_ack still pulses
//  - Outside SHIFT: rd1_bit=rd2_bit=0, bit_idx holds 0.
// CONFIGURATION
//  RF_COMMIT_FWD_EN defined:
//    - start accepted in the COMMIT cycle (back-to-back ops, no IDLE bubble)
//    - any rs equal to the committing rd (with we, and not a discarded reg-0 write)
//      loads wsh instead of the stale register value
//  RF_COMMIT_FWD_EN undefined:
//    - start in COMMIT ignored; min start-to-start spacing XLEN+2 cycles
// TESTING
//  1 Reset mid-idle -> every dbg_rdata=0, busy=0, done=0, par_ack=0.
//  2 par write r5=0xA5A50F0F; start rs1=5 rs2=0 at T -> rd1_bit over T+1..T+32 =
//    bits of 0xA5A50F0F LSB-first; rd2_bit all 0; done only at T+33.
//  3 start rd=7 we=1, wd_bit stream of 0x80000001 -> dbg r7=0x80000001 at T+34;
//    same op with rd=0 -> r0 reads 0.
//  4 start and par_we asserted during SHIFT -> both ignored: no register change,
//    par_ack=0, bit_idx sequence unbroken.
//  5 rstn low at bit_idx=10 of a write to r9 -> busy=0 immediately; r9=0; no done pulse.
//  6 start rs1=rd=3 in COMMIT of a write r3<=0x12345678 -> with RF_COMMIT_FWD_EN,
//    rd1_bit streams 0x12345678; without it, start ignored and busy drops at T+34.

Source files
------------

// File: rtl/regfile_serial_nxw_if.sv
// Handshake/bus bundle between the sequencer/ALU side (master) and the bit-serial
// register file (slave): serial op control, result stream, parallel load and debug read.
interface regfile_serial_nxw_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  localparam int BW = $clog2(XLEN);

  logic            start;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic            we;
  logic            wd_bit;
  logic            rd1_bit;
  logic            rd2_bit;
  logic [BW-1:0]   bit_idx;
  logic            busy;
  logic            done;
  logic            par_we;
  logic [AW-1:0]   par_addr;
  logic [XLEN-1:0] par_wd;
  logic            par_ack;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_rdata;

  modport master (
    output start, rs1, rs2, rd, we, wd_bit, par_we, par_addr, par_wd, dbg_addr,
    input  rd1_bit, rd2_bit, bit_idx, busy, done, par_ack, dbg_rdata
  );

  modport slave (
    input  start, rs1, rs2, rd, we, wd_bit, par_we, par_addr, par_wd, dbg_addr,
    output rd1_bit, rd2_bit, bit_idx, busy, done, par_ack, dbg_rdata
  );
endinterface

// File: rtl/regfile_serial_nxw.sv
// NREGS x XLEN register file streaming two operands LSB-first and capturing a serial result.
// Optional RF_COMMIT_FWD_EN: accept start in COMMIT and forward the committing value.
module regfile_serial_nxw #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rstn,
  regfile_serial_nxw_if.slave bus
);
  localparam int            BW       = $clog2(XLEN);
  localparam logic [BW-1:0] LAST_IDX = BW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state_reg;
  logic [BW-1:0]   bit_idx_reg;
  logic [XLEN-1:0] sh1_reg;
  logic [XLEN-1:0] sh2_reg;
  logic [XLEN-1:0] wsh_reg;
  logic [AW-1:0]   rd_reg;
  logic            we_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            par_ack_reg;

  logic [XLEN-1:0] regs [NREGS];

  logic            commit_wr;
  logic            par_wr;
  logic            accept;
  logic [XLEN-1:0] op1_val;
  logic [XLEN-1:0] op2_val;

  assign commit_wr = (state_reg == COMMIT) && we_reg && !((ZERO_REG != 0) && (rd_reg == '0));
  assign par_wr    = (state_reg == IDLE) && !bus.start && bus.par_we;

`ifdef RF_COMMIT_FWD_EN
  // A new op starting in COMMIT must see the value being written this same edge.
  assign accept  = bus.start && ((state_reg == IDLE) || (state_reg == COMMIT));
  assign op1_val = (commit_wr && (bus.rs1 == rd_reg)) ? wsh_reg : regs[bus.rs1];
  assign op2_val = (commit_wr && (bus.rs2 == rd_reg)) ? wsh_reg : regs[bus.rs2];
`else
  assign accept  = bus.start && (state_reg == IDLE);
  assign op1_val = regs[bus.rs1];
  assign op2_val = regs[bus.rs2];
`endif

  // Register array: per-entry flops so the debug port can read combinationally.
  genvar gi;
  for (gi = 0; gi < NREGS; gi++) begin : g_reg
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_flop
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic [XLEN-1:0] q_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          q_reg <= '0;
        end else if (commit_wr && (rd_reg == IDX)) begin
          q_reg <= wsh_reg;
        end else if (par_wr && (bus.par_addr == IDX)) begin
          q_reg <= bus.par_wd;
        end
      end
      assign regs[gi] = q_reg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
      sh1_reg     <= '0;
      sh2_reg     <= '0;
      wsh_reg     <= '0;
      rd_reg      <= '0;
      we_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      par_ack_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      par_ack_reg <= par_wr;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sh1_reg     <= op1_val;
            sh2_reg     <= op2_val;
            rd_reg      <= bus.rd;
            we_reg      <= bus.we;
            bit_idx_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          sh1_reg <= sh1_reg >> 1;
          sh2_reg <= sh2_reg >> 1;
          wsh_reg <= {bus.wd_bit, wsh_reg[XLEN-1:1]};
          if (bit_idx_reg == LAST_IDX) begin
            bit_idx_reg <= '0;
            done_reg    <= 1'b1;
            state_reg   <= COMMIT;
          end else begin
            bit_idx_reg <= bit_idx_reg + BW'(1);
          end
        end
        COMMIT: begin
          if (accept) begin
            sh1_reg     <= op1_val;
            sh2_reg     <= op2_val;
            rd_reg      <= bus.rd;
            we_reg      <= bus.we;
            bit_idx_reg <= '0;
            state_reg   <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd1_bit   = sh1_reg[0] & (state_reg == SHIFT);
  assign bus.rd2_bit   = sh2_reg[0] & (state_reg == SHIFT);
  assign bus.bit_idx   = bit_idx_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.par_ack   = par_ack_reg;
  assign bus.dbg_rdata = regs[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_serial_nxw.sv
// Self-checking bench for regfile_serial_nxw: a register model plus an expected-operand
// queue filled as ops are issued and drained as the serial streams are collected.
module tb_regfile_serial_nxw;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;
  localparam int BW    = $clog2(XLEN);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  regfile_serial_nxw_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_serial_nxw #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int              pass_cnt  = 0;
  int              total_cnt = 0;
  logic [XLEN-1:0] mdl [NREGS];
  logic [XLEN-1:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.we = 1'b0;
    bus.wd_bit = 1'b0; bus.par_we = 1'b0; bus.par_addr = '0; bus.par_wd = '0;
    bus.dbg_addr = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
  endtask

  // One-cycle parallel write; returns in the cycle where par_ack should be high.
  task automatic par_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.par_we = 1'b1; bus.par_addr = a; bus.par_wd = d;
    $display("par_write r%0d <= %h", a, d);
    step();
    bus.par_we = 1'b0;
    if (a != 0) mdl[a] = d;
  endtask

  task automatic dbg_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d);
    bus.dbg_addr = a;
    #1;
    d = bus.dbg_rdata;
  endtask

  // Issue start in the current cycle; returns in the first SHIFT cycle.
  task automatic begin_op(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input logic [AW-1:0] d, input logic w);
    bus.start = 1'b1; bus.rs1 = s1; bus.rs2 = s2; bus.rd = d; bus.we = w;
    $display("serial_op rs1=r%0d rs2=r%0d rd=r%0d we=%0b", s1, s2, d, w);
    step();
    bus.start = 1'b0;
  endtask

  // Collects XLEN operand bits while feeding wval; returns in the COMMIT cycle.
  task automatic shift_window(input logic [XLEN-1:0] wval, input int inj_k,
                              output logic [XLEN-1:0] g1, output logic [XLEN-1:0] g2,
                              output int idx_err, output logic early_done,
                              output logic ack_seen);
    idx_err = 0; early_done = 1'b0; ack_seen = 1'b0; g1 = '0; g2 = '0;
    for (int k = 0; k < XLEN; k++) begin
      if (bus.bit_idx !== BW'(k) || bus.busy !== 1'b1) idx_err++;
      g1[k] = bus.rd1_bit;
      g2[k] = bus.rd2_bit;
      early_done = early_done | bus.done;
      ack_seen   = ack_seen | bus.par_ack;
      bus.wd_bit = wval[k];
      if (k == inj_k) begin
        bus.start = 1'b1; bus.rs1 = 5'd2; bus.par_we = 1'b1;
        bus.par_addr = 5'd11; bus.par_wd = 32'hDEADBEEF;
      end else begin
        bus.start = 1'b0; bus.par_we = 1'b0;
      end
      step();
    end
    bus.wd_bit = 1'b0;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] d;
    int nz;
    par_write(5'd4, 32'hCAFEF00D);
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (bus.par_ack !== 1'b0) $display("FAIL reset_par_ack: got %b expected 0", bus.par_ack);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done);
    else pass_cnt++;
    nz = 0;
    for (int i = 0; i < NREGS; i++) begin
      dbg_read(AW'(i), d);
      if (d !== '0) nz++;
    end
    total_cnt++;
    if (nz != 0) $display("FAIL reset_regs: got %0d nonzero registers expected 0", nz);
    else pass_cnt++;
    clear_model();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] g1, g2, d, e;
    int ie;
    logic ed, as;
    par_write(5'd5, 32'hA5A50F0F);
    total_cnt++;
    if (bus.par_ack !== 1'b1) $display("FAIL par_ack: got %b expected 1", bus.par_ack);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.par_ack !== 1'b0) $display("FAIL par_ack_pulse: got %b expected 0", bus.par_ack);
    else pass_cnt++;
    dbg_read(5'd5, d);
    total_cnt++;
    if (d !== mdl[5]) $display("FAIL dbg_r5: got %h expected %h", d, mdl[5]);
    else pass_cnt++;

    exp_q.push_back(mdl[5]);
    exp_q.push_back('0);
    begin_op(5'd5, 5'd0, 5'd0, 1'b0);
    shift_window('0, -1, g1, g2, ie, ed, as);
    e = exp_q.pop_front();
    total_cnt++;
    if (g1 !== e) $display("FAIL stream_rd1: got %h expected %h", g1, e);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (g2 !== e) $display("FAIL stream_rd2: got %h expected %h", g2, e);
    else pass_cnt++;
    total_cnt++;
    if (ie != 0) $display("FAIL stream_bit_idx: got %0d bad cycles expected 0", ie);
    else pass_cnt++;
    total_cnt++;
    if (ed !== 1'b0) $display("FAIL stream_early_done: got %b expected 0", ed);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL stream_done_T33: got %b expected 1", bus.done);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL stream_idle_T34: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    else pass_cnt++;

    par_write(5'd6, 32'h0000003C);
    step();
    exp_q.push_back(mdl[6]);
    exp_q.push_back(mdl[5]);
    begin_op(5'd6, 5'd5, 5'd0, 1'b0);
    shift_window('0, -1, g1, g2, ie, ed, as);
    e = exp_q.pop_front();
    total_cnt++;
    if (g1 !== e) $display("FAIL stream2_rd1: got %h expected %h", g1, e);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (g2 !== e) $display("FAIL stream2_rd2: got %h expected %h", g2, e);
    else pass_cnt++;
    step();
  endtask

  task automatic test_commit();
    logic [XLEN-1:0] g1, g2, d, e;
    int ie;
    logic ed, as;
    begin_op(5'd0, 5'd0, 5'd7, 1'b1);
    shift_window(32'h80000001, -1, g1, g2, ie, ed, as);
    step();
    mdl[7] = 32'h80000001;
    exp_q.push_back(mdl[7]);
    dbg_read(5'd7, d);
    e = exp_q.pop_front();
    total_cnt++;
    if (d !== e) $display("FAIL commit_r7: got %h expected %h", d, e);
    else pass_cnt++;

    begin_op(5'd0, 5'd0, 5'd0, 1'b1);
    shift_window(32'hFFFFFFFF, -1, g1, g2, ie, ed, as);
    step();
    dbg_read(5'd0, d);
    total_cnt++;
    if (d !== '0) $display("FAIL commit_r0: got %h expected 0", d);
    else pass_cnt++;

    exp_q.push_back(mdl[7]);
    begin_op(5'd7, 5'd0, 5'd7, 1'b0);
    shift_window(32'h12345678, -1, g1, g2, ie, ed, as);
    e = exp_q.pop_front();
    total_cnt++;
    if (g1 !== e) $display("FAIL commit_stream_r7: got %h expected %h", g1, e);
    else pass_cnt++;
    step();
    dbg_read(5'd7, d);
    total_cnt++;
    if (d !== mdl[7]) $display("FAIL commit_we0: got %h expected %h", d, mdl[7]);
    else pass_cnt++;

    par_write(5'd0, 32'hFFFFFFFF);
    total_cnt++;
    if (bus.par_ack !== 1'b1) $display("FAIL par_ack_r0: got %b expected 1", bus.par_ack);
    else pass_cnt++;
    dbg_read(5'd0, d);
    total_cnt++;
    if (d !== '0) $display("FAIL par_r0: got %h expected 0", d);
    else pass_cnt++;
    step();
  endtask

  task automatic test_ignore_in_shift();
    logic [XLEN-1:0] g1, g2, d, e;
    int ie;
    logic ed, as;
    par_write(5'd11, 32'h11111111);
    step();
    exp_q.push_back(mdl[11]);
    begin_op(5'd11, 5'd0, 5'd9, 1'b1);
    shift_window(32'h0F0F1234, 5, g1, g2, ie, ed, as);
    e = exp_q.pop_front();
    total_cnt++;
    if (g1 !== e) $display("FAIL ign_rd1: got %h expected %h", g1, e);
    else pass_cnt++;
    total_cnt++;
    if (ie != 0) $display("FAIL ign_bit_idx: got %0d bad cycles expected 0", ie);
    else pass_cnt++;
    total_cnt++;
    if (as !== 1'b0) $display("FAIL ign_par_ack: got %b expected 0", as);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL ign_done: got %b expected 1", bus.done);
    else pass_cnt++;
    step();
    mdl[9] = 32'h0F0F1234;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL ign_busy_T34: got %b expected 0", bus.busy);
    else pass_cnt++;
    dbg_read(5'd11, d);
    total_cnt++;
    if (d !== mdl[11]) $display("FAIL ign_r11: got %h expected %h", d, mdl[11]);
    else pass_cnt++;
    dbg_read(5'd9, d);
    total_cnt++;
    if (d !== mdl[9]) $display("FAIL ign_r9: got %h expected %h", d, mdl[9]);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [XLEN-1:0] d;
    logic done_seen;
    done_seen = 1'b0;
    begin_op(5'd0, 5'd0, 5'd9, 1'b1);
    for (int k = 0; k < 10; k++) begin
      bus.wd_bit = 1'b1;
      step();
    end
    total_cnt++;
    if (bus.bit_idx !== BW'(10)) $display("FAIL abort_idx10: got %0d expected 10", bus.bit_idx);
    else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.bit_idx !== '0)
      $display("FAIL abort_busy: got busy=%b idx=%0d expected 0 0", bus.busy, bus.bit_idx);
    else pass_cnt++;
    clear_model();
    bus.wd_bit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      done_seen = done_seen | bus.done;
    end
    rstn = 1'b1;
    for (int k = 0; k < XLEN + 4; k++) begin
      step();
      done_seen = done_seen | bus.done;
    end
    total_cnt++;
    if (done_seen !== 1'b0) $display("FAIL abort_done: got %b expected 0", done_seen);
    else pass_cnt++;
    dbg_read(5'd9, d);
    total_cnt++;
    if (d !== mdl[9]) $display("FAIL abort_r9: got %h expected %h", d, mdl[9]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] g1, g2, d;
    int ie;
    logic ed, as;
    begin_op(5'd0, 5'd0, 5'd3, 1'b1);
    shift_window(32'h12345678, -1, g1, g2, ie, ed, as);
    mdl[3] = 32'h12345678;
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL b2b_done: got %b expected 1", bus.done);
    else pass_cnt++;
    bus.start = 1'b1; bus.rs1 = 5'd3; bus.rs2 = 5'd0; bus.rd = 5'd0; bus.we = 1'b0;
    $display("serial_op in COMMIT rs1=r3 rs2=r0 rd=r0 we=0");
    step();
    bus.start = 1'b0;
`ifdef RF_COMMIT_FWD_EN
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy);
    else pass_cnt++;
    exp_q.push_back(mdl[3]);
    shift_window('0, -1, g1, g2, ie, ed, as);
    d = exp_q.pop_front();
    total_cnt++;
    if (g1 !== d) $display("FAIL b2b_fwd_rd1: got %h expected %h", g1, d);
    else pass_cnt++;
    step();
`else
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_busy_T34: got %b expected 0", bus.busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_start_ignored: got busy=%b expected 0", bus.busy);
    else pass_cnt++;
`endif
    dbg_read(5'd3, d);
    total_cnt++;
    if (d !== mdl[3]) $display("FAIL b2b_r3: got %h expected %h", d, mdl[3]);
    else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    clear_model();
    step();
    step();
    rstn = 1'b1;
    step();
    test_reset();
    test_stream();
    test_commit();
    test_ignore_in_shift();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
